phase_shaper_pdm: RTL and testbench

Downstream stage for the phase accumulator. It consumes the accumulator's phase word and turns it into an 8-bit waveform sample: off, saw, triangle or square, scaled by an amplitude. A first-order delta-sigma modulator then converts the sample to a 1-bit PDM stream for a single output pin. Configuration arrives over a valid/ready handshake and is applied only at a phase wrap, so the output never glitches mid-period.

---
 rtl/phase_shaper_pdm_pkg.sv | 22 ++
 rtl/phase_shaper_pdm_pdm_modulator.sv | 34 +++
 rtl/phase_shaper_pdm.sv | 163 ++++++++++++++++
 tb/tb_phase_shaper_pdm.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phase_shaper_pdm_pkg.sv
// Shared types and default widths for the phase shaper / PDM output stage.
//   wave_e      : waveform select carried on cfg_wave
//   cfg_state_e : config handshake FSM states
package phase_shaper_pdm_pkg;

    localparam int unsigned DEF_PHASE_WIDTH  = 16;
    localparam int unsigned DEF_SAMPLE_WIDTH = 8;
    localparam int unsigned DEF_AMP_WIDTH    = 8;

    typedef enum logic [1:0] {
        WAVE_OFF    = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_SQUARE = 2'd3
    } wave_e;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/phase_shaper_pdm_pdm_modulator.sv
// First-order delta-sigma modulator: turns a held multi-bit sample into a
// 1-bit density stream whose long-run duty is sample / 2^SAMPLE_WIDTH.
//   clk, rst : clock, asynchronous active-high reset
//   sample   : level to modulate, sampled every cycle
//   pdm_out  : registered carry of the accumulator
module pdm_modulator #(
    parameter int unsigned SAMPLE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    output logic                    pdm_out
);

    logic [SAMPLE_WIDTH-1:0] acc_q;
    logic                    pdm_q;
    logic [SAMPLE_WIDTH:0]   sum;

    // The carry out of the wrapping accumulator is the output bit.
    assign sum = {1'b0, acc_q} + {1'b0, sample};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= sum[SAMPLE_WIDTH-1:0];
            pdm_q <= sum[SAMPLE_WIDTH];
        end
    end

    assign pdm_out = pdm_q;

endmodule

// File: rtl/phase_shaper_pdm.sv
// Waveform shaper + amplitude scaler + PDM output for a phase accumulator.
// Config (wave, amp) is accepted over valid/ready and only takes effect at a
// phase wrap (or immediately while the output is OFF), so a period is never cut.
//   clk, rst     : clock, asynchronous active-high reset
//   phase_in     : phase word, qualified by phase_valid (no back-pressure)
//   cfg_valid/cfg_ready, cfg_wave, cfg_amp : config handshake
//   sample_out   : scaled sample, updated with a one-cycle sample_valid strobe
//   pdm_out      : 1-bit delta-sigma rendering of sample_out
module phase_shaper_pdm
    import phase_shaper_pdm_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH  = DEF_PHASE_WIDTH,
    parameter int unsigned SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int unsigned AMP_WIDTH    = DEF_AMP_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [PHASE_WIDTH-1:0]  phase_in,
    input  logic                    phase_valid,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [1:0]              cfg_wave,
    input  logic [AMP_WIDTH-1:0]    cfg_amp,
    output logic [SAMPLE_WIDTH-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    pdm_out
);

    localparam int unsigned ProdWidth = SAMPLE_WIDTH + AMP_WIDTH;

    // ---------------- config FSM ----------------
    cfg_state_e             state_q, state_d;
    wave_e                  active_wave_q, pend_wave_q;
    logic [AMP_WIDTH-1:0]   active_amp_q, pend_amp_q;
    logic                   load_pend, apply_pend;
    logic                   prev_msb_q;
    logic                   phase_msb;
    logic                   wrap;

    assign phase_msb = phase_in[PHASE_WIDTH-1];
    assign wrap      = phase_valid && prev_msb_q && !phase_msb;
    assign cfg_ready = (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        load_pend  = 1'b0;
        apply_pend = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cfg_valid) begin
                    load_pend = 1'b1;
                    state_d   = PENDING;
                end
            end
            PENDING: begin
                // Nothing audible to glitch while OFF, so apply right away.
                if (active_wave_q == WAVE_OFF || wrap) begin
                    apply_pend = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pend_wave_q   <= WAVE_OFF;
            pend_amp_q    <= '0;
            active_wave_q <= WAVE_OFF;
            active_amp_q  <= '0;
            prev_msb_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load_pend) begin
                pend_wave_q <= wave_e'(cfg_wave);
                pend_amp_q  <= cfg_amp;
            end
            if (apply_pend) begin
                active_wave_q <= pend_wave_q;
                active_amp_q  <= pend_amp_q;
            end
            if (phase_valid) begin
                prev_msb_q <= phase_msb;
            end
        end
    end

    // ---------------- stage 1: shaping ----------------
    logic [SAMPLE_WIDTH-1:0] shaped;
    logic [SAMPLE_WIDTH-1:0] tri_t;
    logic                    unused_phase_bits;

    assign tri_t             = phase_in[PHASE_WIDTH-2 -: SAMPLE_WIDTH];
    assign unused_phase_bits = ^phase_in[PHASE_WIDTH-SAMPLE_WIDTH-2:0];

    always_comb begin
        shaped = '0;
        unique case (active_wave_q)
            WAVE_OFF:    shaped = '0;
            WAVE_SAW:    shaped = phase_in[PHASE_WIDTH-1 -: SAMPLE_WIDTH];
            WAVE_TRI:    shaped = phase_msb ? ~tri_t : tri_t;
            WAVE_SQUARE: shaped = phase_msb ? '1 : '0;
            default:     shaped = '0;
        endcase
    end

    logic [SAMPLE_WIDTH-1:0] s1_sample_q;
    logic [AMP_WIDTH-1:0]    s1_amp_q;
    logic                    s1_valid_q;

    // Amp travels with its sample: the wrap sample keeps the old amp even
    // though the active registers change on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sample_q <= '0;
            s1_amp_q    <= '0;
            s1_valid_q  <= 1'b0;
        end else begin
            s1_valid_q <= phase_valid;
            if (phase_valid) begin
                s1_sample_q <= shaped;
                s1_amp_q    <= active_amp_q;
            end
        end
    end

    // ---------------- stage 2: scaling ----------------
    logic [ProdWidth-1:0]    prod;
    logic [SAMPLE_WIDTH-1:0] scaled;
    logic [SAMPLE_WIDTH-1:0] sample_q;
    logic                    sample_valid_q;

    assign prod   = {{AMP_WIDTH{1'b0}}, s1_sample_q} * {{SAMPLE_WIDTH{1'b0}}, s1_amp_q};
    assign scaled = SAMPLE_WIDTH'(prod >> AMP_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            sample_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                sample_q <= scaled;
            end
        end
    end

    assign sample_out   = sample_q;
    assign sample_valid = sample_valid_q;

    // ---------------- PDM ----------------
    pdm_modulator #(
        .SAMPLE_WIDTH (SAMPLE_WIDTH)
    ) u_pdm (
        .clk     (clk),
        .rst     (rst),
        .sample  (sample_q),
        .pdm_out (pdm_out)
    );

endmodule

// File: tb/tb_phase_shaper_pdm.sv
// Scoreboard bench for phase_shaper_pdm: expected samples are queued with their
// due cycle when a phase is driven, and popped on the falling edge.
module tb_phase_shaper_pdm;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] phase_in = '0;
    logic        phase_valid = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [1:0]  cfg_wave = '0;
    logic [7:0]  cfg_amp = '0;
    logic [7:0]  sample_out;
    logic        sample_valid;
    logic        pdm_out;

    always #5 clk = ~clk;

    phase_shaper_pdm #(
        .PHASE_WIDTH  (16),
        .SAMPLE_WIDTH (8),
        .AMP_WIDTH    (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .phase_in     (phase_in),
        .phase_valid  (phase_valid),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_wave     (cfg_wave),
        .cfg_amp      (cfg_amp),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .pdm_out      (pdm_out)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;

    typedef struct {
        logic [7:0]  val;
        int unsigned due;
    } exp_t;
    exp_t sb[$];

    // Reference config state
    logic [1:0] m_wave, m_pwave;
    logic [7:0] m_amp, m_pamp;
    logic       m_pend, m_prev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] shape(input logic [1:0] w, input logic [7:0] a,
                                         input logic [15:0] p);
        logic [7:0]  s;
        logic [15:0] prod;
        case (w)
            2'd1:    s = p[15:8];
            2'd2:    s = p[15] ? ~p[14:7] : p[14:7];
            2'd3:    s = p[15] ? 8'hFF : 8'h00;
            default: s = 8'h00;
        endcase
        prod = {8'h00, s} * {8'h00, a};
        return prod[15:8];
    endfunction

    task automatic model_reset();
        m_wave = 2'd0; m_amp = 8'd0; m_pwave = 2'd0; m_pamp = 8'd0;
        m_pend = 1'b0; m_prev = 1'b0;
        sb.delete();
    endtask

    // Advance one clock with the currently driven inputs, updating the model
    // for the edge about to happen.
    task automatic tick();
        logic wrap;
        exp_t e;
        wrap = 1'b0;
        check("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        if (phase_valid) begin
            e.val = shape(m_wave, m_amp, phase_in);
            e.due = cyc + 2;
            sb.push_back(e);
            wrap   = m_prev && !phase_in[15];
            m_prev = phase_in[15];
        end
        if (!m_pend) begin
            if (cfg_valid) begin
                m_pend = 1'b1; m_pwave = cfg_wave; m_pamp = cfg_amp;
            end
        end else if (m_wave == 2'd0 || wrap) begin
            m_wave = m_pwave; m_amp = m_pamp; m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [15:0] p);
        phase_in    = p;
        phase_valid = 1'b1;
        tick();
        phase_valid = 1'b0;
    endtask

    task automatic cfg_req(input logic [1:0] w, input logic [7:0] a);
        logic taken;
        taken     = 1'b0;
        cfg_valid = 1'b1;
        cfg_wave  = w;
        cfg_amp   = a;
        for (int i = 0; i < 50 && !taken; i++) begin
            taken = cfg_ready;
            tick();
        end
        cfg_valid = 1'b0;
        check("cfg_accepted", 32'(taken), 32'd1);
    endtask

    task automatic count_pdm(input int n, output int ones);
        ones = 0;
        for (int i = 0; i < n; i++) begin
            ones += int'(pdm_out);
            tick();
        end
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_sample_out", 32'(sample_out), 32'd0);
        check("rst_sample_valid", 32'(sample_valid), 32'd0);
        check("rst_pdm_out", 32'(pdm_out), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        model_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("sample_valid", 32'(sample_valid), 32'd1);
                check("sample_out", 32'(sample_out), 32'(sb[0].val));
                void'(sb.pop_front());
            end else begin
                check("idle_valid", 32'(sample_valid), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        int ones;
        model_reset();

        async_reset();

        // Config while OFF applies after one pending cycle
        cfg_req(2'd1, 8'd255);
        idle(2);
        send(16'h8000);                      // SAW 128*255>>8 = 127
        idle(3);

        // Deferred apply: wrap sample still SAW, next one TRI
        cfg_req(2'd2, 8'd255);
        send(16'h9000);
        send(16'hF000);
        send(16'h1000);                      // wrap
        send(16'h4000);                      // TRI 127
        idle(3);

        // TRI folding
        send(16'hC000);                      // 126
        send(16'h0000);                      // 0
        idle(3);

        // SQUARE amp 65 -> 64, PDM duty 64/256
        cfg_req(2'd3, 8'd65);
        send(16'h8000);
        send(16'h0000);                      // wrap, applies
        send(16'h8000);
        idle(4);
        count_pdm(256, ones);
        check("pdm_ones_64", 32'(ones), 32'd64);

        // Maximum sample 254 must not be a constant 1
        cfg_req(2'd3, 8'd255);
        send(16'h0000);                      // wrap, applies
        send(16'h8000);
        idle(4);
        count_pdm(256, ones);
        check("pdm_ones_254", 32'(ones), 32'd254);

        // Reset mid-operation
        async_reset();

        // Reset while PENDING discards the request
        cfg_req(2'd1, 8'd200);
        idle(2);
        send(16'h8000);                      // SAW 128*200>>8 = 100
        idle(3);
        cfg_req(2'd2, 8'd100);
        idle(2);
        async_reset();
        send(16'h8000);
        send(16'hC000);
        send(16'h0000);
        idle(3);
        count_pdm(32, ones);
        check("pdm_ones_off", 32'(ones), 32'd0);
        idle(4);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
